// File: rtl/hpm_share_arb.sv
// Round-robin share of one fixed-latency half-precision multiplier between two
// requesters. Each requester has a response FIFO. Issue is gated by per-requester
// credits, so a result coming out of the pipeline always has a free FIFO slot.
module hpm_share_arb #(
  parameter int LAT   = 2,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        mul_valid,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [15:0] mul_res,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_data,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  // run holds ready low while reset is asserted and for the first edge after
  // release, so the grant never reaches the ports during reset.
  logic           run;
  logic           last_gnt;   // 1: requester 1 was granted most recently
  logic           mul_tag;
  logic [LAT-1:0] dl_v;
  logic [LAT-1:0] dl_t;
  logic [CW-1:0]  in_flight [2];
  logic [CW-1:0]  occ [2];
  logic [PW-1:0]  wr_ptr [2];
  logic [PW-1:0]  rd_ptr [2];
  logic [15:0]    mem [2][DEPTH];
  logic [1:0]     elig;
  logic [1:0]     gnt;
  logic [1:0]     push;
  logic [1:0]     pop;
  logic [1:0]     has_data;
  logic           accept;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Credit check and round-robin grant; credits freed by a pop count only next cycle.
  always_comb begin
    elig    = '0;
    gnt     = '0;
    elig[0] = run & req0_valid & ((in_flight[0] + occ[0]) < CRED_MAX);
    elig[1] = run & req1_valid & ((in_flight[1] + occ[1]) < CRED_MAX);
    gnt[0]  = elig[0] & (~elig[1] | last_gnt);
    gnt[1]  = elig[1] & (~elig[0] | ~last_gnt);
  end

  assign accept     = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Completion and pop decode from the end of the delay line and the FIFO state.
  always_comb begin
    push        = '0;
    has_data    = '0;
    push[0]     = dl_v[LAT-1] & ~dl_t[LAT-1];
    push[1]     = dl_v[LAT-1] &  dl_t[LAT-1];
    has_data[0] = (occ[0] != '0);
    has_data[1] = (occ[1] != '0);
    pop         = has_data & {rsp1_ready, rsp0_ready};
  end

  // Registered issue to the multiplier and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      last_gnt  <= 1'b1;
      mul_valid <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_tag   <= 1'b0;
    end else begin
      run       <= 1'b1;
      mul_valid <= accept;
      if (accept) begin
        mul_a    <= gnt[1] ? req1_a : req0_a;
        mul_b    <= gnt[1] ? req1_b : req0_b;
        mul_tag  <= gnt[1];
        last_gnt <= gnt[1];
      end
    end
  end

  // Tag/valid delay line matched to the multiplier latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v <= '0;
      dl_t <= '0;
    end else begin
      dl_v[0] <= mul_valid;
      dl_t[0] <= mul_tag;
      for (int k = 1; k < LAT; k++) begin
        dl_v[k] <= dl_v[k-1];
        dl_t[k] <= dl_t[k-1];
      end
    end
  end

  // Per-requester in-flight counters, occupancy and response FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        in_flight[i] <= '0;
        occ[i]       <= '0;
        wr_ptr[i]    <= '0;
        rd_ptr[i]    <= '0;
        for (int k = 0; k < DEPTH; k++) mem[i][k] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({gnt[i], push[i]})
          2'b10:   in_flight[i] <= in_flight[i] + 1'b1;
          2'b01:   in_flight[i] <= in_flight[i] - 1'b1;
          default: in_flight[i] <= in_flight[i];
        endcase
        case ({push[i], pop[i]})
          2'b10:   occ[i] <= occ[i] + 1'b1;
          2'b01:   occ[i] <= occ[i] - 1'b1;
          default: occ[i] <= occ[i];
        endcase
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= mul_res;
          wr_ptr[i]         <= ptr_next(wr_ptr[i]);
        end
        if (pop[i]) rd_ptr[i] <= ptr_next(rd_ptr[i]);
      end
    end
  end

  assign rsp0_valid = has_data[0];
  assign rsp1_valid = has_data[1];
  assign rsp0_data  = mem[0][rd_ptr[0]];
  assign rsp1_data  = mem[1][rd_ptr[1]];
  assign busy       = mul_valid | (|dl_v) | (|has_data);

endmodule
